// File: rtl/floo_pkg.sv
// Shared types and constants for the FlooNoC wormhole output arbiter.
// Contents: arb_state_e (IDLE/LOCKED), performance counter widths, and
// idx_width() which returns the grant-index width for a requester count.
package floo_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned FlitCntW  = 32;
    localparam int unsigned StallCntW = 16;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/floo_rr_select.sv
// Pointer-based round-robin search: grants the first asserted request at or
// above ptr, wrapping from NumInp-1 back to 0.
// Ports: req (request vector), ptr (search start), gnt (one-hot grant),
//        gnt_idx (index of the grant), gnt_valid (any request present).
module floo_rr_select
    import floo_pkg::*;
#(
    parameter int unsigned NumInp = 5,
    localparam int unsigned IdxW  = idx_width(NumInp)
) (
    input  logic [NumInp-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumInp-1:0] gnt,
    output logic [IdxW-1:0]   gnt_idx,
    output logic              gnt_valid
);

    logic [IdxW-1:0] hi_idx;
    logic [IdxW-1:0] lo_idx;
    logic            hi_found;
    logic            lo_found;

    // Lowest request at/above ptr wins; otherwise the lowest request overall (wrap).
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = int'(NumInp) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx   = IdxW'(i);
                lo_found = 1'b1;
                if (IdxW'(i) >= ptr) begin
                    hi_idx   = IdxW'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt       = '0;
        gnt_valid = lo_found;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
        if (lo_found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/floo_wormhole_arbiter.sv
// Wormhole (packet-locked) round-robin arbiter with a registered output flit.
// Once a non-tail flit is accepted the winning input keeps the grant until its
// tail flit is accepted; the round-robin pointer then moves past it.
// Ports: clk_i, rst_ni (synchronous, active-low); valid_i/ready_o/data_i/last_i
//        per requester; valid_o/ready_i/data_o/last_o output flit; gnt_idx_o
//        source of the held flit; flit_cnt_o/stall_cnt_o performance counters.
// Build option: FLOO_ARB_PERF_CNT_EN enables the counters (tied to 0 otherwise).
module floo_wormhole_arbiter
    import floo_pkg::*;
#(
    parameter int unsigned NumInp    = 5,
    parameter int unsigned FlitWidth = 64,
    localparam int unsigned IdxW     = idx_width(NumInp)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumInp-1:0]                valid_i,
    output logic [NumInp-1:0]                ready_o,
    input  logic [NumInp-1:0][FlitWidth-1:0] data_i,
    input  logic [NumInp-1:0]                last_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [FlitWidth-1:0]             data_o,
    output logic                             last_o,
    output logic [IdxW-1:0]                  gnt_idx_o,
    output logic [FlitCntW-1:0]              flit_cnt_o,
    output logic [StallCntW-1:0]             stall_cnt_o
);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;

    logic [NumInp-1:0] sel_req;
    logic [NumInp-1:0] sel_gnt;
    logic [IdxW-1:0]   sel_ptr;
    logic [IdxW-1:0]   sel_idx;
    logic              sel_valid;
    logic              out_free;
    logic              in_hs;
    logic              out_hs;

    // While a packet is open only its owner may compete.
    always_comb begin
        sel_req = valid_i;
        sel_ptr = rr_ptr_q;
        if (state_q == LOCKED) begin
            sel_req             = '0;
            sel_req[lock_idx_q] = valid_i[lock_idx_q];
            sel_ptr             = lock_idx_q;
        end
    end

    floo_rr_select #(
        .NumInp (NumInp)
    ) i_rr_select (
        .req       (sel_req),
        .ptr       (sel_ptr),
        .gnt       (sel_gnt),
        .gnt_idx   (sel_idx),
        .gnt_valid (sel_valid)
    );

    assign out_free = ~valid_o | ready_i;
    assign in_hs    = sel_valid & out_free;
    assign out_hs   = valid_o & ready_i;
    assign ready_o  = (rst_ni && out_free) ? sel_gnt : '0;

    // Lock on non-tail flits, release and advance the pointer on the tail.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (in_hs) begin
            if (last_i[sel_idx]) begin
                state_d  = IDLE;
                rr_ptr_d = (sel_idx == IdxW'(NumInp - 1)) ? '0 : sel_idx + IdxW'(1);
            end else begin
                state_d    = LOCKED;
                lock_idx_d = sel_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Output flit register: load on input handshake, drain on output handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_o   <= 1'b0;
            data_o    <= '0;
            last_o    <= 1'b0;
            gnt_idx_o <= '0;
        end else if (in_hs) begin
            valid_o   <= 1'b1;
            data_o    <= data_i[sel_idx];
            last_o    <= last_i[sel_idx];
            gnt_idx_o <= sel_idx;
        end else if (ready_i) begin
            valid_o   <= 1'b0;
        end
    end

`ifdef FLOO_ARB_PERF_CNT_EN
    logic [FlitCntW-1:0]  flit_cnt_q;
    logic [StallCntW-1:0] stall_cnt_q;

    // Flit count wraps; stall count saturates.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_hs) begin
                flit_cnt_q <= flit_cnt_q + FlitCntW'(1);
            end
            if (valid_o && !ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + StallCntW'(1);
            end
        end
    end

    assign flit_cnt_o  = flit_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign flit_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

endmodule
